// File: rtl/cprv_if_stage_if.sv
// Bus bundle between the instruction-fetch stage, instruction memory and decode.
// Handshakes: a fetch is accepted on a rising edge where imem_req_o && imem_gnt_i; responses
// return in order, one per cycle, no earlier than the cycle after grant (imem_rvalid_i has no
// back-pressure); an instruction moves to decode on a rising edge where valid_id_o && ready_id_i.
interface cprv_if_stage_if #(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 64
);
  logic                   imem_req_o;
  logic [ADDR_WIDTH-1:0]  imem_addr_o;
  logic                   imem_gnt_i;
  logic                   imem_rvalid_i;
  logic [INSTR_WIDTH-1:0] imem_rdata_i;
  logic                   redirect_i;
  logic [ADDR_WIDTH-1:0]  redirect_pc_i;
  logic                   valid_id_o;
  logic                   ready_id_i;
  logic [INSTR_WIDTH-1:0] instr_data_id_o;
  logic [ADDR_WIDTH-1:0]  pc_id_o;

  modport master (
    output imem_req_o, imem_addr_o, valid_id_o, instr_data_id_o, pc_id_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, ready_id_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, valid_id_o, instr_data_id_o, pc_id_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, ready_id_i
  );
endinterface

// File: rtl/cprv_if_stage.sv
// Instruction fetch stage: credit-limited fetch PC, tag FIFO of issued PCs, instruction buffer
// toward decode, and redirect handling that drops responses of abandoned fetches.
module cprv_if_stage #(
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    ADDR_WIDTH  = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 64'h0,
  parameter int                    BUF_DEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  cprv_if_stage_if.master bus
);
  localparam int PW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW  = PW + 1;
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] DEPTH_L = CW1'(BUF_DEPTH);

  logic                   run_q;
  logic [ADDR_WIDTH-1:0]  pc_q;
  logic [CW-1:0]          outst_q;
  logic [CW-1:0]          discard_q;
  logic [CW-1:0]          count_q;
  logic [PW-1:0]          rd_q;
  logic [PW-1:0]          wr_q;
  logic [PW-1:0]          tag_rd_q;
  logic [PW-1:0]          tag_wr_q;
  logic [INSTR_WIDTH-1:0] data_mem [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_mem   [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0]  tag_mem  [BUF_DEPTH];

  logic          valid;
  logic          rsp;
  logic          live;
  logic          drop;
  logic          pop;
  logic          req;
  logic          grant;
  logic [CW:0]   used;

  // A pop this cycle frees a credit immediately so a full-rate stream never stalls.
  always_comb begin
    valid = (count_q != '0);
    rsp   = bus.imem_rvalid_i && (outst_q != '0);
    live  = rsp && (discard_q == '0) && !bus.redirect_i;
    drop  = rsp && (discard_q != '0) && !bus.redirect_i;
    pop   = valid && bus.ready_id_i && !bus.redirect_i;
    used  = {1'b0, outst_q} + {1'b0, count_q} - {{CW{1'b0}}, pop};
    req   = run_q && !bus.redirect_i && (used < DEPTH_L);
    grant = req && bus.imem_gnt_i;
  end

  assign bus.imem_req_o      = req;
  assign bus.imem_addr_o     = pc_q;
  assign bus.valid_id_o      = valid;
  assign bus.instr_data_id_o = valid ? data_mem[rd_q] : '0;
  assign bus.pc_id_o         = valid ? pc_mem[rd_q]   : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q     <= 1'b0;
      pc_q      <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
      count_q   <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      tag_rd_q  <= '0;
      tag_wr_q  <= '0;
    end else begin
      run_q <= 1'b1;
      if (grant && !rsp) begin
        outst_q <= outst_q + CW'(1);
      end else if (!grant && rsp) begin
        outst_q <= outst_q - CW'(1);
      end
      if (bus.redirect_i) begin
        // Everything still in flight after this edge belongs to the abandoned path.
        pc_q      <= {bus.redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
        discard_q <= outst_q - CW'(rsp);
        count_q   <= '0;
        rd_q      <= '0;
        wr_q      <= '0;
        tag_rd_q  <= '0;
        tag_wr_q  <= '0;
      end else begin
        if (grant) begin
          pc_q     <= pc_q + ADDR_WIDTH'(4);
          tag_wr_q <= tag_wr_q + PW'(1);
        end
        if (drop) begin
          discard_q <= discard_q - CW'(1);
        end
        if (live) begin
          wr_q     <= wr_q + PW'(1);
          tag_rd_q <= tag_rd_q + PW'(1);
        end
        if (pop) begin
          rd_q <= rd_q + PW'(1);
        end
        count_q <= count_q + CW'(live) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      tag_mem[tag_wr_q] <= pc_q;
    end
    if (live) begin
      data_mem[wr_q] <= bus.imem_rdata_i;
      pc_mem[wr_q]   <= tag_mem[tag_rd_q];
    end
  end
endmodule

// File: tb/tb_cprv_if_stage.sv
// Bench for cprv_if_stage: an instruction-memory responder, a stream-level reference of which
// fetches must reach decode, directed corner sequences and a redirect vector table.
module tb_cprv_if_stage;
  localparam int IW    = 32;
  localparam int AW    = 64;
  localparam int DEPTH = 2;
  localparam logic [AW-1:0] RST_PC = 64'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cprv_if_stage_if #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

  cprv_if_stage #(
    .INSTR_WIDTH(IW),
    .ADDR_WIDTH (AW),
    .RESET_PC   (RST_PC),
    .BUF_DEPTH  (DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
    int            epoch;
  } pend_t;

  typedef struct {
    logic [AW-1:0] pc;
    int            cyc;
  } log_t;

  typedef struct {
    logic [AW-1:0] target;
    logic [AW-1:0] exp_addr;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gnt_pct, ready_pct, rv_pct, lat_min, lat_max, redir_permil;
  bit force_redir = 1'b0;
  logic [AW-1:0] force_target;

  pend_t pend[$];
  logic [AW-1:0] exp_q[$];
  log_t dlog[$];
  logic [AW-1:0] exp_fetch;
  int avail = 0;
  int epoch = 0;
  bit last_req;
  logic [AW-1:0] last_addr;
  vec_t vecs[6];

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    logic [31:0] t;
    t = a[31:0] ^ a[63:32];
    return (t * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  function automatic logic [AW-1:0] align4(input logic [AW-1:0] a);
    return {a[AW-1:2], 2'b00};
  endfunction

  function automatic logic [AW-1:0] log_pc(input int i);
    return (i < dlog.size()) ? dlog[i].pc : '1;
  endfunction

  function automatic int log_cyc(input int i);
    return (i < dlog.size()) ? dlog[i].cyc : -1;
  endfunction

  task automatic set_mode(input int g, input int r, input int v, input int lmin, input int lmax,
                          input int rd);
    gnt_pct = g; ready_pct = r; rv_pct = v; lat_min = lmin; lat_max = lmax; redir_permil = rd;
  endtask

  // ---------------- driver: reset ----------------
  task automatic apply_reset();
    bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;
    bus.redirect_i = 1'b0; bus.redirect_pc_i = '0; bus.ready_id_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_req", bus.imem_req_o, 0);
    chk("rst_valid", bus.valid_id_o, 0);
    chk("rst_instr", bus.instr_data_id_o, 0);
    chk("rst_pc_id", bus.pc_id_o, 0);
    chk("rst_addr", bus.imem_addr_o, RST_PC);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("req_before_first_edge", bus.imem_req_o, 0);
    @(posedge clk);
    #1;
    cyc++;
    pend.delete(); exp_q.delete(); dlog.delete();
    exp_fetch = RST_PC; avail = 0; epoch++;
  endtask

  // ---------------- driver + scoreboard: one clock cycle ----------------
  task automatic do_cycle();
    bit rv, redir, g, rdy, req, vld, pop;
    logic [AW-1:0] tgt, addr, exp_pc;
    pend_t r;
    rv    = (pend.size() != 0) && (pend[0].due <= cyc) && ($urandom_range(99) < rv_pct);
    g     = ($urandom_range(99) < gnt_pct);
    rdy   = ($urandom_range(99) < ready_pct);
    redir = force_redir || ($urandom_range(999) < redir_permil);
    tgt   = force_redir ? force_target : {$urandom(), $urandom()};
    force_redir = 1'b0;
    bus.imem_rvalid_i = rv;
    bus.imem_rdata_i  = rv ? mem_word(pend[0].addr) : '0;
    bus.imem_gnt_i    = g;
    bus.ready_id_i    = rdy;
    bus.redirect_i    = redir;
    bus.redirect_pc_i = tgt;
    @(negedge clk);
    req = bus.imem_req_o;
    vld = bus.valid_id_o;
    addr = bus.imem_addr_o;
    last_req = req;
    last_addr = addr;
    pop = vld && rdy && !redir;
    chk("valid_vs_model", vld, (avail != 0));
    if (pop) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_delivery actual_pc=%h expected=none cycle=%0d", bus.pc_id_o, cyc);
      end else begin
        exp_pc = exp_q.pop_front();
        chk("pc_id", bus.pc_id_o, exp_pc);
        chk("instr_id", bus.instr_data_id_o, mem_word(exp_pc));
      end
      dlog.push_back('{pc: bus.pc_id_o, cyc: cyc});
      if (avail > 0) avail--;
    end
    if (req) begin
      chk("credit", (pend.size() + avail < DEPTH), 1);
      chk("fetch_addr", addr, exp_fetch);
    end
    if (redir) chk("req_in_redirect", req, 0);
    if (rv) begin
      r = pend.pop_front();
      if (r.epoch == epoch && !redir) avail++;
    end
    if (redir) begin
      exp_q.delete();
      exp_fetch = align4(tgt);
      avail = 0;
      epoch++;
    end else if (req && g) begin
      pend.push_back('{addr: addr, due: cyc + $urandom_range(lat_max, lat_min), epoch: epoch});
      exp_q.push_back(addr);
      exp_fetch = exp_fetch + 64'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int c0;
    vecs[0] = '{target: 64'h203,                exp_addr: 64'h200};
    vecs[1] = '{target: 64'h100,                exp_addr: 64'h100};
    vecs[2] = '{target: 64'h7,                  exp_addr: 64'h4};
    vecs[3] = '{target: 64'hFFFF_FFFF_FFFF_FFFF, exp_addr: 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[4] = '{target: 64'h1001,               exp_addr: 64'h1000};
    vecs[5] = '{target: 64'h2,                  exp_addr: 64'h0};

    bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;
    bus.redirect_i = 1'b0; bus.redirect_pc_i = '0; bus.ready_id_i = 1'b0;
    #2;

    // Full-rate stream: grant always, 1-cycle latency, decode always ready.
    apply_reset();
    set_mode(100, 100, 100, 1, 1, 0);
    c0 = cyc;
    repeat (12) do_cycle();
    chk("first_latency", log_cyc(0), c0 + 2);
    for (int i = 0; i < 8; i++) begin
      chk("stream_pc", log_pc(i), 64'(4 * i));
      chk("stream_cycle", log_cyc(i), c0 + 2 + i);
    end

    // Decode stalled: buffer fills, request drops, head held.
    apply_reset();
    set_mode(100, 0, 100, 1, 1, 0);
    for (int i = 0; i < 6; i++) begin
      do_cycle();
      if (bus.valid_id_o) chk("head_hold", bus.pc_id_o, 64'h0);
    end
    chk("stall_valid", bus.valid_id_o, 1);
    chk("stall_req_low", last_req, 0);
    set_mode(100, 100, 100, 1, 1, 0);
    repeat (8) do_cycle();
    for (int i = 0; i < 3; i++) chk("resume_pc", log_pc(i), 64'(4 * i));

    // Redirect with pc 8 and 12 outstanding.
    apply_reset();
    set_mode(100, 100, 100, 2, 2, 0);
    for (int i = 0; i < 40; i++) begin
      if (pend.size() == 2 && pend[0].addr == 64'h8 && pend[1].addr == 64'hC) break;
      do_cycle();
    end
    chk("setup_two_outstanding", (pend.size() == 2 && pend[0].addr == 64'h8), 1);
    c0 = dlog.size();
    force_redir = 1'b1;
    force_target = 64'h100;
    repeat (10) do_cycle();
    chk("redir_first_pc", log_pc(c0), 64'h100);
    chk("redir_second_pc", log_pc(c0 + 1), 64'h104);

    // Redirect target alignment table.
    set_mode(50, 100, 100, 1, 3, 0);
    for (int i = 0; i < 6; i++) begin
      force_redir = 1'b1;
      force_target = vecs[i].target;
      do_cycle();
      chk("redir_addr", bus.imem_addr_o, vecs[i].exp_addr);
      chk("redir_flush", bus.valid_id_o, 0);
      repeat (4) do_cycle();
    end

    // Grant withheld, then long latency.
    apply_reset();
    set_mode(0, 100, 100, 4, 4, 0);
    for (int i = 0; i < 3; i++) begin
      do_cycle();
      chk("req_held", last_req, 1);
      chk("addr_held", last_addr, RST_PC);
    end
    set_mode(100, 100, 100, 4, 4, 0);
    repeat (30) do_cycle();
    chk("lat4_throughput", (dlog.size() >= 8), 1);

    // Reset with the buffer full, then a stray response before any grant.
    apply_reset();
    set_mode(100, 0, 100, 1, 1, 0);
    repeat (6) do_cycle();
    chk("full_before_reset", bus.valid_id_o, 1);
    apply_reset();
    bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'hDEAD_BEEF;
    bus.ready_id_i = 1'b1; bus.redirect_i = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    bus.imem_rvalid_i = 1'b0;
    chk("stray_rvalid_ignored", bus.valid_id_o, 0);
    set_mode(100, 100, 100, 1, 1, 0);
    repeat (10) do_cycle();
    chk("restart_count", (dlog.size() >= 3), 1);
    chk("restart_pc", log_pc(0), RST_PC);

    // Randomized traffic with redirects and a mid-run reset.
    set_mode(70, 70, 80, 1, 4, 30);
    repeat (1500) do_cycle();
    apply_reset();
    repeat (1500) do_cycle();
    set_mode(0, 100, 100, 1, 4, 0);
    for (int i = 0; i < 60 && (pend.size() != 0 || avail != 0); i++) do_cycle();
    do_cycle();
    chk("drain_pend", pend.size(), 0);
    chk("drain_exp_q", exp_q.size(), 0);
    chk("drain_valid", bus.valid_id_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cprv_if_stage.md
CPRV_IF_STAGE -- requirements
Module: cprv_if_stage

Interface
REQ-001 SHALL have parameter INSTR_WIDTH, default 32, instruction word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, PC/fetch address width.
REQ-003 SHALL have parameter RESET_PC, default 64'h0, first fetch address after reset.
REQ-004 SHALL have parameter BUF_DEPTH, default 2, instruction buffer entries (power of two, >=2).
REQ-005 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port imem_req_o, output, 1, fetch request valid.
REQ-008 SHALL have port imem_addr_o, output, ADDR_WIDTH, fetch address.
REQ-009 SHALL have port imem_gnt_i, input, 1, request accepted this cycle.
REQ-010 SHALL have port imem_rvalid_i, input, 1, response data valid.
REQ-011 SHALL have port imem_rdata_i, input, INSTR_WIDTH, response instruction.
REQ-012 SHALL have port redirect_i, input, 1, control-flow redirect (branch/jump).
REQ-013 SHALL have port redirect_pc_i, input, ADDR_WIDTH, redirect target.
REQ-014 SHALL have port valid_id_o, output, 1, instruction valid to ID stage.
REQ-015 SHALL have port ready_id_i, input, 1, ID stage ready.
REQ-016 SHALL have port instr_data_id_o, output, INSTR_WIDTH, instruction to ID stage.
REQ-017 SHALL have port pc_id_o, output, ADDR_WIDTH, PC of instr_data_id_o.

Function
REQ-018 SHALL hold fetch PC register; imem_addr_o = PC; request accepted when imem_req_o && imem_gnt_i, then PC <= PC + 4 (wraps modulo 2^ADDR_WIDTH).
REQ-019 SHALL keep imem_addr_o stable while imem_req_o high and not granted, except on redirect.
REQ-020 SHALL assert imem_req_o only when outstanding + buffer occupancy < BUF_DEPTH and redirect_i low (credit rule; buffer never overflows).
REQ-021 SHALL treat responses as in-order, one per cycle max, latency >=1 cycle after grant; outstanding count +1 on grant, -1 on rvalid, both same cycle = no change.
REQ-022 SHALL push {imem_rdata_i, PC of that request} into FIFO buffer on accepted (non-discarded) rvalid; tag FIFO of issued PCs or equivalent SHALL provide the PC.
REQ-023 SHALL drive valid_id_o = buffer not empty; instr_data_id_o/pc_id_o = head entry; pop on valid_id_o && ready_id_i.
REQ-024 SHALL hold head entry stable while valid_id_o && !ready_id_i.
REQ-025 SHALL support push and pop in same cycle, including full and single-entry cases; no bubble inserted.
REQ-026 SHALL pass data only via buffer: zero-cycle combinational path rvalid->valid_id_o forbidden; minimum rvalid-to-valid_id_o latency 1 cycle.
REQ-027 On redirect_i SHALL: load PC <= {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00}; empty buffer; set discard count = outstanding (minus rvalid of this cycle); deassert imem_req_o this cycle.
REQ-028 SHALL drop (not push) rvalid responses while discard count > 0, decrementing it each; rvalid in the redirect cycle itself SHALL also be dropped.
REQ-029 SHALL treat valid_id_o in redirect cycle as stale: buffer cleared next edge regardless of ready_id_i; a pop in that cycle has no other effect.
REQ-030 SHALL allow back-to-back redirects; each reloads PC, discard count accumulates correctly, no stale instruction ever reaches ID.
REQ-031 SHALL sustain one instruction per cycle when imem grants every cycle with 1-cycle latency and ready_id_i high.

Reset
REQ-032 SHALL on rst_n low asynchronously set: PC=RESET_PC, buffer empty, outstanding=0, discard=0, imem_req_o=0, valid_id_o=0, instr_data_id_o=0, pc_id_o=0.
REQ-033 SHALL assert first imem_req_o no earlier than first rising edge after rst_n deassertion; reset mid-operation SHALL abandon all in-flight responses (rvalid ignored until new grant).

Verification
REQ-034 Reset release, imem gnt always, 1-cycle latency, ready_id_i=1 -> pc_id_o 0,4,8,12 on consecutive cycles, valid_id_o continuous.
REQ-035 ready_id_i=0 for 5 cycles -> buffer fills to 2, imem_req_o drops, head (pc 0) held stable; ready back -> pcs 0,4,8 in order, none lost/duplicated.
REQ-036 Two requests outstanding (pc 8,12), redirect_i with redirect_pc_i=0x100 -> both responses dropped, next pc_id_o = 0x100, then 0x104.
REQ-037 redirect_pc_i=0x203 -> imem_addr_o = 0x200.
REQ-038 imem_gnt_i withheld 3 cycles -> imem_addr_o constant, imem_req_o high throughout; rvalid latency 4 cycles -> no throughput loss beyond credit limit.
REQ-039 rst_n pulsed low with buffer full -> outputs at reset values immediately; fetch restarts at RESET_PC.
